pixel_pkt_gen: RTL

PIXEL_PKT_GEN -- requirements
Module: pixel_pkt_gen

---
 rtl/pixel_pkt_pkg.sv | 27 ++
 rtl/pixel_pkt_gen_if.sv | 23 ++
 rtl/pixel_pkt_gen_byte_sel.sv | 51 +++++
 rtl/pixel_pkt_gen.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pixel_pkt_pkg.sv
// Shared constants, state encoding and header payload type for the pixel packet generator.
package pixel_pkt_pkg;

    localparam logic [7:0] SOF0 = 8'hEA;
    localparam logic [7:0] SOF1 = 8'hFF;
    localparam logic [7:0] EOF0 = 8'hAA;
    localparam logic [7:0] EOF1 = 8'hDD;

    localparam int unsigned SOF_LEN      = 2;
    localparam int unsigned HDR_LEN      = 6;
    localparam int unsigned TRL_LEN      = 3;
    localparam int unsigned PKT_OVERHEAD = SOF_LEN + HDR_LEN + TRL_LEN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2,
        ST_PAD    = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  dtype;
        logic [15:0] dlen;
        logic [7:0]  seq;
    } pkt_hdr_t;

endpackage

// File: rtl/pixel_pkt_gen_if.sv
// Payload handshake bundle: the producer drives the payload, the generator answers ready/err.
interface pixel_pkt_gen_if #(
    parameter int unsigned DLEN_MAX = 256
) ();

    logic [DLEN_MAX*8-1:0] data;
    logic [15:0]           dlen;
    logic [7:0]            dtype;
    logic                  data_valid;
    logic                  data_ready;
    logic                  err;

    modport master (
        output data, dlen, dtype, data_valid,
        input  data_ready, err
    );

    modport slave (
        input  data, dlen, dtype, data_valid,
        output data_ready, err
    );

endinterface

// File: rtl/pixel_pkt_gen_byte_sel.sv
// Returns stream byte n of the packet from the latched header, payload and checksum.
module pkt_byte_sel
    import pixel_pkt_pkg::*;
#(
    parameter int unsigned DLEN_MAX = 256,
    parameter logic [7:0]  PHL_ID   = 8'h00
) (
    input  logic [15:0]           n,
    input  pkt_hdr_t              hdr,
    input  logic [DLEN_MAX*8-1:0] payload,
    input  logic [7:0]            ck,
    output logic [7:0]            byte_c
);

    localparam int unsigned PIW       = (DLEN_MAX > 1) ? $clog2(DLEN_MAX) : 1;
    localparam int unsigned PAY_START = SOF_LEN + HDR_LEN;

    logic [16:0]    n_w;
    logic [16:0]    pay_end;
    logic [PIW-1:0] pay_idx;

    assign n_w     = 17'(n);
    assign pay_end = 17'(hdr.dlen) + 17'(PAY_START);
    assign pay_idx = PIW'(n - 16'(PAY_START));

    // Byte map: SOF, header, payload, checksum, EOF, then zero padding.
    always_comb begin
        byte_c = 8'h00;
        if (n_w < 17'(SOF_LEN)) begin
            byte_c = n[0] ? SOF1 : SOF0;
        end else if (n_w < 17'(PAY_START)) begin
            case (n[2:0])
                3'd2:    byte_c = PHL_ID;
                3'd3:    byte_c = hdr.dtype;
                3'd4:    byte_c = hdr.dlen[7:0];
                3'd5:    byte_c = hdr.dlen[15:8];
                3'd6:    byte_c = hdr.seq;
                default: byte_c = 8'h00;
            endcase
        end else if (n_w < pay_end) begin
            byte_c = payload[{pay_idx, 3'b000} +: 8];
        end else if (n_w == pay_end) begin
            byte_c = ck;
        end else if (n_w == pay_end + 17'd1) begin
            byte_c = EOF0;
        end else if (n_w == pay_end + 17'd2) begin
            byte_c = EOF1;
        end
    end

endmodule

// File: rtl/pixel_pkt_gen.sv
// Embeds one framed packet per video frame into the pixel stream, BPP bytes per active pixel.
module pixel_pkt_gen
    import pixel_pkt_pkg::*;
#(
    parameter int unsigned BPP      = 6,
    parameter int unsigned DLEN_MAX = 256,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter logic [7:0]  PHL_ID   = 8'h00
) (
    input  logic              tx_pixel_clk,
    input  logic              rst,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic              de,
    pixel_pkt_gen_if.slave    pif,
    output logic [BPP*8-1:0]  pixel_value,
    output logic              pix_valid,
    output logic              busy
);

    localparam int unsigned PW = BPP * 8;
    localparam int unsigned LW = 17;

    // The whole packet must fit inside one frame.
    if (DLEN_MAX + PKT_OVERHEAD > BPP * H_ACTIVE * V_ACTIVE) begin : g_size_check
        $error("pixel_pkt_gen: DLEN_MAX packet does not fit in one frame");
    end

    state_t                state;
    logic [7:0]            seq;
    logic [7:0]            ck;
    logic [7:0]            dtype_q;
    logic [15:0]           dlen_q;
    logic [DLEN_MAX*8-1:0] payload;
    logic [15:0]           base;

    pkt_hdr_t   hdr_c;
    logic [PW-1:0] word_c;
    logic [7:0] pay_xor_c;
    logic [LW-1:0] pkt_len_c;
    logic       hs_c, bad_c, sof_c, eof_c, last_word_c;

    assign pif.data_ready = (state == ST_IDLE);
    assign hs_c        = pif.data_valid & pif.data_ready;
    assign bad_c       = (pif.dlen == 16'd0) || (32'(pif.dlen) > DLEN_MAX);
    assign sof_c       = de && (x == '0) && (y == '0);
    assign eof_c       = de && (x == XW'(H_ACTIVE - 1)) && (y == YW'(V_ACTIVE - 1));
    assign pkt_len_c   = LW'(dlen_q) + LW'(PKT_OVERHEAD);
    assign last_word_c = (LW'(base) + LW'(BPP)) >= pkt_len_c;
    assign hdr_c       = '{dtype: dtype_q, dlen: dlen_q, seq: seq};

    // Payload XOR over the valid bytes, folded into the checksum at acceptance.
    always_comb begin
        pay_xor_c = 8'h00;
        for (int unsigned i = 0; i < DLEN_MAX; i++) begin
            if (16'(i) < pif.dlen) pay_xor_c = pay_xor_c ^ pif.data[8*i +: 8];
        end
    end

    for (genvar k = 0; k < BPP; k++) begin : g_byte
        pkt_byte_sel #(
            .DLEN_MAX (DLEN_MAX),
            .PHL_ID   (PHL_ID)
        ) u_sel (
            .n       (base + 16'(k)),
            .hdr     (hdr_c),
            .payload (payload),
            .ck      (ck),
            .byte_c  (word_c[8*k +: 8])
        );
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            seq         <= 8'h00;
            ck          <= 8'h00;
            dtype_q     <= 8'h00;
            dlen_q      <= 16'h0000;
            payload     <= '0;
            base        <= 16'h0000;
            pixel_value <= '0;
            pix_valid   <= 1'b0;
            busy        <= 1'b0;
            pif.err     <= 1'b0;
        end else begin
            pix_valid   <= de;
            pixel_value <= '0;
            pif.err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hs_c && bad_c) begin
                        pif.err <= 1'b1;
                    end else if (hs_c) begin
                        payload <= pif.data;
                        dtype_q <= pif.dtype;
                        dlen_q  <= pif.dlen;
                        ck      <= PHL_ID ^ pif.dtype ^ pif.dlen[7:0] ^ pif.dlen[15:8]
                                   ^ seq ^ pay_xor_c;
                        state   <= ST_ARMED;
                        busy    <= 1'b1;
                    end
                end
                // Word 0 goes out on the frame-start pixel itself.
                ST_ARMED, ST_STREAM: begin
                    if (de && (state == ST_STREAM || sof_c)) begin
                        pixel_value <= word_c;
                        if (last_word_c) begin
                            base  <= 16'h0000;
                            seq   <= 8'(seq + 8'd1);
                            state <= eof_c ? ST_IDLE : ST_PAD;
                            busy  <= !eof_c;
                        end else begin
                            base  <= base + 16'(BPP);
                            state <= ST_STREAM;
                        end
                    end
                end
                ST_PAD: begin
                    if (eof_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
